// File: rtl/mul_div_if.sv
// mul_div_if: request/response and Register_File write-port bundle for mul_div_unit
interface mul_div_if #(parameter int W = 8, parameter int D = 3);
  logic         start;
  logic         op_div;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [D-1:0] addr;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic         rf_reg_write;
  logic         rf_zero_store;
  logic         rf_immediate;
  logic [D-1:0] rf_addr;
  logic [W-1:0] rf_data;
  modport master (
    output start, op_div, op_a, op_b, addr,
    input  busy, done, div_zero, rf_reg_write, rf_zero_store, rf_immediate, rf_addr, rf_data
  );
  modport slave (
    input  start, op_div, op_a, op_b, addr,
    output busy, done, div_zero, rf_reg_write, rf_zero_store, rf_immediate, rf_addr, rf_data
  );
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle unsigned shift-add multiply / restoring divide with two-cycle Register_File writeback
module mul_div_unit #(
  parameter int W = 8,
  parameter int D = 3
) (
  input  logic clk,
  input  logic reset,
  mul_div_if.slave bus
);
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  typedef enum logic [1:0] {IDLE, CALC, WB_LO, WB_HI} state_t;
  state_t         state_q, state_d;
  logic [CW-1:0]  count_q, count_d;
  logic [W-1:0]   m_q, m_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   rem_q, rem_d;
  logic           div_q, div_d;
  logic           dz_q, dz_d;
  logic [D-1:0]   addr_q, addr_d;
  logic [W:0]     sum, shr;
  logic           ge;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      m_q     <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      div_q   <= 1'b0;
      dz_q    <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      dz_q    <= dz_d;
      addr_q  <= addr_d;
    end
  end
  // m holds the multiplicand or the divisor; acc low half holds multiplier or dividend/quotient
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    m_d     = m_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    div_d   = div_q;
    dz_d    = dz_q;
    addr_d  = addr_q;
    sum     = {1'b0, acc_q[2*W-1:W]} + {1'b0, m_q};
    shr     = {rem_q, acc_q[W-1]};
    ge      = shr >= {1'b0, m_q};
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = CALC;
        count_d = '0;
        m_d     = bus.op_div ? bus.op_b : bus.op_a;
        acc_d   = {{W{1'b0}}, bus.op_div ? bus.op_a : bus.op_b};
        rem_d   = '0;
        div_d   = bus.op_div;
        dz_d    = 1'b0;
        addr_d  = bus.addr;
      end
      CALC: begin
        count_d = (count_q == CW'(W - 1)) ? '0 : count_q + 1'b1;
        state_d = (count_q == CW'(W - 1)) ? WB_LO : CALC;
        acc_d   = div_q ? {acc_q[2*W-1:W], acc_q[W-2:0], ge}
                : acc_q[0] ? {sum, acc_q[W-1:1]} : {1'b0, acc_q[2*W-1:1]};
        rem_d   = !div_q ? rem_q : ge ? W'(shr - {1'b0, m_q}) : shr[W-1:0];
      end
      WB_LO: begin
        state_d = WB_HI;
        dz_d    = div_q && (m_q == '0);
      end
      default: state_d = IDLE;
    endcase
  end
  assign bus.busy          = state_q != IDLE;
  assign bus.done          = state_q == WB_HI;
  assign bus.div_zero      = dz_q;
  assign bus.rf_reg_write  = (state_q == WB_LO) || (state_q == WB_HI);
  assign bus.rf_zero_store = state_q == WB_LO;
  assign bus.rf_immediate  = 1'b0;
  assign bus.rf_addr       = (state_q == WB_HI) ? addr_q : '0;
  assign bus.rf_data       = (state_q == WB_LO) ? acc_q[W-1:0]
                           : (state_q == WB_HI) ? (div_q ? rem_q : acc_q[2*W-1:W]) : '0;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: randomized and directed checks of mul_div_unit against an arithmetic reference
module tb_mul_div_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   errs = 0;
  mul_div_if #(.W(8), .D(3)) bus ();
  mul_div_unit #(.W(8), .D(3)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [15:0] model(input logic dv, input logic [7:0] a, input logic [7:0] b);
    if (!dv) return 16'(int'(a) * int'(b));
    if (b == 8'd0) return {a, 8'hFF};
    return {8'(a % b), 8'(a / b)};
  endfunction
  task automatic run_op(input logic dv, input logic [7:0] a, input logic [7:0] b, input logic [2:0] ad,
                        input bit junk, output int calc_bad, output logic [7:0] lo_d, output logic lo_we,
                        output logic lo_zs, output logic [7:0] hi_d, output logic [2:0] hi_ad,
                        output logic hi_we, output logic hi_zs, output logic hi_done,
                        output logic first_dz, output logic post_dz, output logic post_busy);
    bus.start = 1'b1; bus.op_div = dv; bus.op_a = a; bus.op_b = b; bus.addr = ad;
    calc_bad = 0;
    @(negedge clk);
    first_dz = bus.div_zero;
    for (int i = 0; i < 8; i++) begin
      if (bus.busy !== 1'b1 || bus.rf_reg_write !== 1'b0 || bus.rf_zero_store !== 1'b0 || bus.done !== 1'b0 ||
          bus.rf_data !== 8'd0 || bus.rf_addr !== 3'd0 || bus.rf_immediate !== 1'b0) calc_bad++;
      bus.start = junk; bus.op_div = 1'($urandom); bus.op_a = 8'($urandom); bus.op_b = 8'($urandom);
      bus.addr = 3'($urandom);
      @(negedge clk);
    end
    bus.start = 1'b0;
    lo_d = bus.rf_data; lo_we = bus.rf_reg_write; lo_zs = bus.rf_zero_store;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) calc_bad++;
    @(negedge clk);
    hi_d = bus.rf_data; hi_ad = bus.rf_addr; hi_we = bus.rf_reg_write; hi_zs = bus.rf_zero_store;
    hi_done = bus.done;
    if (bus.busy !== 1'b1) calc_bad++;
    @(negedge clk);
    post_busy = bus.busy; post_dz = bus.div_zero;
    if (bus.rf_reg_write !== 1'b0 || bus.done !== 1'b0) calc_bad++;
  endtask
  int          cb;
  logic [7:0]  lo_d, hi_d;
  logic [2:0]  hi_ad;
  logic        lo_we, lo_zs, hi_we, hi_zs, hi_done, fdz, pdz, pbusy;
  logic [15:0] exp_r;
  task automatic test_reset();
    reset = 1'b1; bus.start = 1'b0; bus.op_div = 1'b0; bus.op_a = '0; bus.op_b = '0; bus.addr = '0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.div_zero !== 1'b0 || bus.rf_reg_write !== 1'b0 ||
          bus.rf_zero_store !== 1'b0 || bus.rf_immediate !== 1'b0 || bus.rf_addr !== 3'd0 || bus.rf_data !== 8'd0) begin
        errs++;
        $display("FAIL reset_outputs cycle %0d: got busy=%b done=%b dz=%b we=%b zs=%b addr=%0d data=%h, want all 0",
                 i, bus.busy, bus.done, bus.div_zero, bus.rf_reg_write, bus.rf_zero_store, bus.rf_addr, bus.rf_data);
      end
    end
    reset = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_mul();
    logic [7:0] ta [5] = '{8'd13, 8'd200, 8'd255, 8'd0, 8'd1};
    logic [7:0] tb [5] = '{8'd11, 8'd200, 8'd255, 8'd123, 8'd1};
    logic [2:0] tad [5] = '{3'd2, 3'd5, 3'd7, 3'd4, 3'd0};
    for (int i = 0; i < 5; i++) begin
      run_op(1'b0, ta[i], tb[i], tad[i], 1'b0, cb, lo_d, lo_we, lo_zs, hi_d, hi_ad, hi_we, hi_zs, hi_done, fdz, pdz, pbusy);
      exp_r = model(1'b0, ta[i], tb[i]);
      vectors++;
      if (lo_d !== exp_r[7:0] || lo_we !== 1'b1 || lo_zs !== 1'b1) begin
        errs++;
        $display("FAIL mul_wb_lo %0d*%0d: got data=%h we=%b zs=%b, want data=%h we=1 zs=1", ta[i], tb[i], lo_d, lo_we, lo_zs, exp_r[7:0]);
      end
      vectors++;
      if (hi_d !== exp_r[15:8] || hi_ad !== tad[i] || hi_we !== 1'b1 || hi_zs !== 1'b0 || hi_done !== 1'b1) begin
        errs++;
        $display("FAIL mul_wb_hi %0d*%0d: got data=%h addr=%0d we=%b zs=%b done=%b, want data=%h addr=%0d we=1 zs=0 done=1",
                 ta[i], tb[i], hi_d, hi_ad, hi_we, hi_zs, hi_done, exp_r[15:8], tad[i]);
      end
      vectors++;
      if (cb !== 0 || pbusy !== 1'b0 || pdz !== 1'b0) begin
        errs++;
        $display("FAIL mul_timing %0d*%0d: got bad_cycles=%0d idle_busy=%b dz=%b, want 0 0 0", ta[i], tb[i], cb, pbusy, pdz);
      end
    end
  endtask
  task automatic test_div();
    logic [7:0] ta [5] = '{8'd100, 8'd55, 8'd255, 8'd7, 8'd255};
    logic [7:0] tb [5] = '{8'd7, 8'd0, 8'd1, 8'd100, 8'd16};
    logic [2:0] tad [5] = '{3'd3, 3'd1, 3'd6, 3'd2, 3'd0};
    for (int i = 0; i < 5; i++) begin
      run_op(1'b1, ta[i], tb[i], tad[i], 1'b0, cb, lo_d, lo_we, lo_zs, hi_d, hi_ad, hi_we, hi_zs, hi_done, fdz, pdz, pbusy);
      exp_r = model(1'b1, ta[i], tb[i]);
      vectors++;
      if (lo_d !== exp_r[7:0] || lo_we !== 1'b1 || lo_zs !== 1'b1) begin
        errs++;
        $display("FAIL div_wb_lo %0d/%0d: got data=%h we=%b zs=%b, want data=%h we=1 zs=1", ta[i], tb[i], lo_d, lo_we, lo_zs, exp_r[7:0]);
      end
      vectors++;
      if (hi_d !== exp_r[15:8] || hi_ad !== tad[i] || hi_we !== 1'b1 || hi_zs !== 1'b0 || hi_done !== 1'b1) begin
        errs++;
        $display("FAIL div_wb_hi %0d/%0d: got data=%h addr=%0d done=%b, want data=%h addr=%0d done=1",
                 ta[i], tb[i], hi_d, hi_ad, hi_done, exp_r[15:8], tad[i]);
      end
      vectors++;
      if (pdz !== (tb[i] == 8'd0) || fdz !== 1'b0 || cb !== 0 || pbusy !== 1'b0) begin
        errs++;
        $display("FAIL div_zero_flag %0d/%0d: got dz=%b dz_after_start=%b bad_cycles=%0d, want dz=%b 0 0",
                 ta[i], tb[i], pdz, fdz, cb, tb[i] == 8'd0);
      end
    end
  endtask
  task automatic test_random();
    logic dv;
    logic [7:0] a, b;
    logic [2:0] ad;
    for (int i = 0; i < 24; i++) begin
      dv = 1'($urandom); a = 8'($urandom);
      b = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
      ad = 3'($urandom);
      run_op(dv, a, b, ad, 1'b0, cb, lo_d, lo_we, lo_zs, hi_d, hi_ad, hi_we, hi_zs, hi_done, fdz, pdz, pbusy);
      exp_r = model(dv, a, b);
      vectors++;
      if ({hi_d, lo_d} !== exp_r || hi_ad !== ad || pdz !== (dv && b == 8'd0) || fdz !== 1'b0 || cb !== 0) begin
        errs++;
        $display("FAIL random div=%b a=%0d b=%0d: got hi=%h lo=%h addr=%0d dz=%b bad=%0d, want hi=%h lo=%h addr=%0d dz=%b",
                 dv, a, b, hi_d, lo_d, hi_ad, pdz, cb, exp_r[15:8], exp_r[7:0], ad, dv && b == 8'd0);
      end
    end
  endtask
  task automatic test_start_while_busy();
    logic dv;
    logic [7:0] a, b;
    logic [2:0] ad;
    for (int i = 0; i < 4; i++) begin
      dv = i[0]; a = 8'($urandom); b = 8'($urandom_range(1, 255)); ad = 3'($urandom);
      run_op(dv, a, b, ad, 1'b1, cb, lo_d, lo_we, lo_zs, hi_d, hi_ad, hi_we, hi_zs, hi_done, fdz, pdz, pbusy);
      exp_r = model(dv, a, b);
      vectors++;
      if ({hi_d, lo_d} !== exp_r || hi_ad !== ad || cb !== 0 || pbusy !== 1'b0) begin
        errs++;
        $display("FAIL start_while_busy div=%b a=%0d b=%0d: got hi=%h lo=%h addr=%0d bad=%0d, want hi=%h lo=%h addr=%0d",
                 dv, a, b, hi_d, lo_d, hi_ad, cb, exp_r[15:8], exp_r[7:0], ad);
      end
    end
  endtask
  task automatic test_reset_mid_calc();
    int bad = 0;
    bus.start = 1'b1; bus.op_div = 1'b0; bus.op_a = 8'd99; bus.op_b = 8'd77; bus.addr = 3'd6;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vectors++;
    if (bus.busy !== 1'b0 || bus.rf_reg_write !== 1'b0 || bus.rf_data !== 8'd0) begin
      errs++;
      $display("FAIL reset_mid_calc_idle: got busy=%b we=%b data=%h, want 0 0 00", bus.busy, bus.rf_reg_write, bus.rf_data);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.rf_reg_write !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) bad++;
    end
    vectors++;
    if (bad !== 0) begin
      errs++;
      $display("FAIL reset_mid_calc_no_write: got %0d cycles with activity, want 0", bad);
    end
    run_op(1'b1, 8'd200, 8'd9, 3'd4, 1'b0, cb, lo_d, lo_we, lo_zs, hi_d, hi_ad, hi_we, hi_zs, hi_done, fdz, pdz, pbusy);
    exp_r = model(1'b1, 8'd200, 8'd9);
    vectors++;
    if ({hi_d, lo_d} !== exp_r || hi_ad !== 3'd4 || cb !== 0) begin
      errs++;
      $display("FAIL reset_mid_calc_next_op: got hi=%h lo=%h addr=%0d bad=%0d, want hi=%h lo=%h addr=4",
               hi_d, lo_d, hi_ad, cb, exp_r[15:8], exp_r[7:0]);
    end
  endtask
  task automatic test_back_to_back();
    logic [7:0] a, b;
    for (int i = 0; i < 4; i++) begin
      a = 8'($urandom); b = 8'($urandom);
      run_op(i[0], a, b, 3'(i), 1'b0, cb, lo_d, lo_we, lo_zs, hi_d, hi_ad, hi_we, hi_zs, hi_done, fdz, pdz, pbusy);
      exp_r = model(i[0], a, b);
      vectors++;
      if ({hi_d, lo_d} !== exp_r || hi_ad !== 3'(i) || cb !== 0 || lo_we !== 1'b1 || hi_done !== 1'b1) begin
        errs++;
        $display("FAIL back_to_back %0d div=%b a=%0d b=%0d: got hi=%h lo=%h addr=%0d bad=%0d, want hi=%h lo=%h addr=%0d",
                 i, i[0], a, b, hi_d, lo_d, hi_ad, cb, exp_r[15:8], exp_r[7:0], i);
      end
    end
  endtask
  initial begin
    test_reset();
    test_mul();
    test_div();
    test_random();
    test_start_while_busy();
    test_reset_mid_calc();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
